// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC coefficient statistics scanner:
// FSM encoding, CAVLC block lengths, trailing-ones cap, count-field widths
// and the TotalZeros helper.
package cavlc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Block lengths: luma 4x4, AC (DC removed), chroma DC 2x2
  localparam int unsigned BLK_LUMA = 16;
  localparam int unsigned BLK_AC   = 15;
  localparam int unsigned BLK_CDC  = 4;

  localparam int unsigned T1_MAX = 3;

  localparam int unsigned TC_W  = 5;  // total_coeff
  localparam int unsigned TZ_W  = 4;  // total_zeros
  localparam int unsigned T1_W  = 2;  // trailing_ones
  localparam int unsigned T1S_W = 3;  // t1_signs
  localparam int unsigned IDX_W = 4;  // coefficient index
  localparam int unsigned LEN_W = 5;  // blk_len

  // Zeros below the last nonzero: (last + 1 - total_coeff) in 5 bits, truncated
  function automatic logic [TZ_W-1:0] calc_total_zeros(input logic [TC_W-1:0]  tc,
                                                       input logic [IDX_W-1:0] last);
    logic [TC_W-1:0] span;
    span = TC_W'(last) + TC_W'(1);
    if (tc == '0) begin
      return '0;
    end
    return TZ_W'(span - tc);
  endfunction

endpackage

// File: rtl/cavlc_coeff_classify.sv
// Combinational classifier for one signed coefficient.
//   coeff   : WIDTH-bit two's complement coefficient
//   is_zero : coefficient is zero
//   is_pm1  : coefficient is exactly +1 or -1 (the most negative value is not)
//   sign    : 1 when negative
module cavlc_coeff_classify #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] coeff,
  output logic             is_zero,
  output logic             is_pm1,
  output logic             sign
);

  // Direct compares against +1 and all-ones avoid any abs() overflow on -2^(WIDTH-1)
  assign is_zero = (coeff == '0);
  assign is_pm1  = (coeff == WIDTH'(1)) || (coeff == '1);
  assign sign    = coeff[WIDTH-1];

endmodule

// File: rtl/cavlc_coeff_stats_scan.sv
// Serial CAVLC statistics scanner. Accepts one zig-zag ordered block over a
// valid/ready handshake, walks it from index L-1 down to 0 (one coefficient per
// cycle) and reports TotalCoeff, TotalZeros, TrailingOnes with signs and the
// index of the highest nonzero coefficient.
//   clk, rst         : clock, synchronous active-high reset
//   coeff_in         : flattened block, coefficient i at [i*WIDTH +: WIDTH]
//   blk_len          : block length (out-of-range values mean MAX_COEFF)
//   in_valid/ready   : input handshake
//   total_coeff ..   : registered results, meaningful while out_valid = 1
//   out_valid/ready  : output handshake
module cavlc_coeff_stats_scan
  import cavlc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COEFF = BLK_LUMA
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MAX_COEFF*WIDTH-1:0] coeff_in,
  input  logic [LEN_W-1:0]           blk_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [TC_W-1:0]            total_coeff,
  output logic [TZ_W-1:0]            total_zeros,
  output logic [T1_W-1:0]            trailing_ones,
  output logic [T1S_W-1:0]           t1_signs,
  output logic [IDX_W-1:0]           last_nz_idx,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_COEFF);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               t1_open_q, t1_open_d;
  logic [TC_W-1:0]    tc_q, tc_d;
  logic [T1_W-1:0]    t1_q, t1_d;
  logic [T1S_W-1:0]   t1s_q, t1s_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [TC_W-1:0]    total_coeff_d;
  logic [TZ_W-1:0]    total_zeros_d;
  logic [T1_W-1:0]    trailing_ones_d;
  logic [T1S_W-1:0]   t1_signs_d;
  logic [IDX_W-1:0]   last_nz_idx_d;
  logic               out_valid_d;
  logic               in_ready_d;

  logic [WIDTH-1:0]   coeff_q [MAX_COEFF];
  logic [WIDTH-1:0]   cur_coeff;
  logic               cur_zero, cur_pm1, cur_sign;
  logic               accept;
  logic [LEN_W-1:0]   eff_len;

  assign accept    = in_valid && in_ready;
  assign cur_coeff = coeff_q[idx_q];
  assign eff_len   = ((blk_len != '0) && (blk_len <= LEN_MAX)) ? blk_len : LEN_MAX;

  cavlc_coeff_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .coeff   (cur_coeff),
    .is_zero (cur_zero),
    .is_pm1  (cur_pm1),
    .sign    (cur_sign)
  );

  // Next-state and result computation
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    t1_open_d       = t1_open_q;
    tc_d            = tc_q;
    t1_d            = t1_q;
    t1s_d           = t1s_q;
    last_d          = last_q;
    total_coeff_d   = total_coeff;
    total_zeros_d   = total_zeros;
    trailing_ones_d = trailing_ones;
    t1_signs_d      = t1_signs;
    last_nz_idx_d   = last_nz_idx;
    out_valid_d     = out_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d     = IDX_W'(eff_len - LEN_W'(1));
          t1_open_d = 1'b1;
          tc_d      = '0;
          t1_d      = '0;
          t1s_d     = '0;
          last_d    = '0;
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!cur_zero) begin
          tc_d = tc_q + TC_W'(1);
          // Scanning top-down, so the first nonzero met is the highest one
          if (tc_q == '0) begin
            last_d = idx_q;
          end
          if (t1_open_q && cur_pm1 && (t1_q < T1_W'(T1_MAX))) begin
            t1_d         = t1_q + T1_W'(1);
            t1s_d[t1_q]  = cur_sign;
          end else begin
            t1_open_d = 1'b0;
          end
        end

        if (idx_q == '0) begin
          total_coeff_d   = tc_d;
          total_zeros_d   = calc_total_zeros(tc_d, last_d);
          trailing_ones_d = t1_d;
          t1_signs_d      = t1s_d;
          last_nz_idx_d   = last_d;
          out_valid_d     = 1'b1;
          state_d         = ST_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  // Control, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      t1_open_q     <= 1'b0;
      tc_q          <= '0;
      t1_q          <= '0;
      t1s_q         <= '0;
      last_q        <= '0;
      total_coeff   <= '0;
      total_zeros   <= '0;
      trailing_ones <= '0;
      t1_signs      <= '0;
      last_nz_idx   <= '0;
      out_valid     <= 1'b0;
      in_ready      <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      t1_open_q     <= t1_open_d;
      tc_q          <= tc_d;
      t1_q          <= t1_d;
      t1s_q         <= t1s_d;
      last_q        <= last_d;
      total_coeff   <= total_coeff_d;
      total_zeros   <= total_zeros_d;
      trailing_ones <= trailing_ones_d;
      t1_signs      <= t1_signs_d;
      last_nz_idx   <= last_nz_idx_d;
      out_valid     <= out_valid_d;
      in_ready      <= in_ready_d;
    end
  end

  // Block capture; data only, no reset needed
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < int'(MAX_COEFF); i++) begin
        coeff_q[i] <= coeff_in[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cavlc_coeff_stats_scan.sv
// Scoreboard bench for cavlc_coeff_stats_scan: the driver pushes hand-computed
// expectations on acceptance; a monitor pops and compares on each out handshake.
module tb_cavlc_coeff_stats_scan;

  localparam int W = 8;
  localparam int N = 16;

  typedef logic signed [W-1:0] blk_t [N];
  typedef struct {
    int     tc;
    int     tz;
    int     t1;
    int     t1s;
    int     last;
    int     len;
    longint acc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] coeff_in = '0;
  logic [4:0]     blk_len = 5'd16;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [4:0]     total_coeff;
  logic [3:0]     total_zeros;
  logic [1:0]     trailing_ones;
  logic [2:0]     t1_signs;
  logic [3:0]     last_nz_idx;
  logic           out_valid;
  logic           out_ready = 1'b1;

  exp_t   sb[$];
  int     ntests = 0;
  int     nfail  = 0;
  longint cyc    = 0;

  logic   mon_pv   = 1'b0;
  longint mon_rise = 0;
  exp_t   mon_e;

  cavlc_coeff_stats_scan #(.WIDTH(W), .MAX_COEFF(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .coeff_in      (coeff_in),
    .blk_len       (blk_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .total_coeff   (total_coeff),
    .total_zeros   (total_zeros),
    .trailing_ones (trailing_ones),
    .t1_signs      (t1_signs),
    .last_nz_idx   (last_nz_idx),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int tc, input int tz, input int t1, input int t1s,
                              input int last, input int len);
    exp_t e;
    e.tc = tc; e.tz = tz; e.t1 = t1; e.t1s = t1s; e.last = last; e.len = len; e.acc = 0;
    return e;
  endfunction

  function automatic logic [N*W-1:0] pack(input blk_t b);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = b[i];
    return v;
  endfunction

  // Present a block and wait (bounded) for its acceptance edge
  task automatic send(input blk_t b, input int len, input exp_t e, output longint acc);
    bit got = 0;
    acc = 0;
    @(negedge clk);
    coeff_in = pack(b);
    blk_len  = 5'(len);
    in_valid = 1'b1;
    for (int k = 0; k < 60 && !got; k++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
    else begin
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    if (!seen) check("valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: latency from accept to out_valid rise, and result fields at handshake
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) mon_pv = 1'b0;
      else begin
        if (out_valid && !mon_pv) mon_rise = cyc;
        mon_pv = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("unexpected_result", 1, 0);
          else begin
            mon_e = sb.pop_front();
            check("total_coeff",   total_coeff,   mon_e.tc);
            check("total_zeros",   total_zeros,   mon_e.tz);
            check("trailing_ones", trailing_ones, mon_e.t1);
            check("t1_signs",      t1_signs,      mon_e.t1s);
            check("last_nz_idx",   last_nz_idx,   mon_e.last);
            check("latency",       mon_rise - mon_e.acc, mon_e.len);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t   b1, b2, b3, b4, b5;
    longint acc, hs_c;

    b1 = '{default: '0}; b1[1] = 3; b1[2] = -1; b1[5] = -1; b1[6] = 1; b1[8] = 1;
    b2 = '{default: '0}; b2[0] = 1; b2[1] = -1; b2[2] = 1; b2[3] = 1; b2[4] = -1;
    b3 = '{default: 8'sd5}; b3[0] = 0; b3[1] = 0; b3[2] = 2; b3[3] = 0;
    b4 = '{default: '0};
    b5 = '{default: '0}; b5[15] = -128; b5[14] = -1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_total_coeff", total_coeff, 0);
    check("rst_total_zeros", total_zeros, 0);
    check("rst_trailing_ones", trailing_ones, 0);
    check("rst_t1_signs", t1_signs, 0);
    check("rst_last_nz_idx", last_nz_idx, 0);
    rst = 1'b0;

    send(b1, 16, mk(5, 4, 3, 4, 8, 16), acc);
    send(b2, 16, mk(5, 0, 3, 1, 4, 16), acc);
    send(b3, 4,  mk(1, 2, 0, 0, 2, 4), acc);
    send(b3, 15, mk(12, 3, 0, 0, 14, 15), acc);
    send(b4, 16, mk(0, 0, 0, 0, 0, 16), acc);
    send(b5, 16, mk(2, 14, 0, 0, 15, 16), acc);
    send(b2, 0,  mk(5, 0, 3, 1, 4, 16), acc);
    send(b2, 31, mk(5, 0, 3, 1, 4, 16), acc);
    drain();

    // Back-pressure in DONE with a second block waiting
    out_ready = 1'b0;
    send(b1, 16, mk(5, 4, 3, 4, 8, 16), acc);
    wait_valid();
    coeff_in = pack(b2);
    blk_len  = 5'd16;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_total_coeff", total_coeff, 5);
      check("stall_t1_signs", t1_signs, 4);
      check("stall_last_nz_idx", last_nz_idx, 8);
    end
    @(negedge clk);
    out_ready = 1'b1;
    hs_c = cyc;
    send(b2, 16, mk(5, 0, 3, 1, 4, 16), acc);
    check("accept_after_out_hs", acc - hs_c, 2);
    drain();

    // Reset in the middle of a scan (idx = 7)
    send(b1, 16, mk(5, 4, 3, 4, 8, 16), acc);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_total_coeff", total_coeff, 0);
    check("midrst_total_zeros", total_zeros, 0);
    check("midrst_trailing_ones", trailing_ones, 0);
    check("midrst_t1_signs", t1_signs, 0);
    check("midrst_last_nz_idx", last_nz_idx, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_result", out_valid, 0);

    send(b5, 16, mk(2, 14, 0, 0, 15, 16), acc);
    send(b1, 16, mk(5, 4, 3, 4, 8, 16), acc);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/cavlc_coeff_stats_scan.md
Name: cavlc_coeff_stats_scan

Overview:
Parametrised successor to the CAVLC pre-processing stage. It accepts one zig-zag-ordered block of signed quantised coefficients (4, 15 or 16 entries, selectable per block) over a valid/ready handshake. It scans the block serially from the highest index down and returns the H.264 CAVLC syntax statistics: TotalCoeff, TotalZeros (zeros before the last nonzero only), TrailingOnes (capped at 3, exact ±1 magnitude) with their sign bits, and the last-nonzero index. It sits between the zig-zag reorder buffer and the coeff_token/level/run encoders.

Parameters:
WIDTH, 8, coefficient width; signed two's complement.
MAX_COEFF, 16, maximum coefficients per block. Supported values are 4 to 16.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
coeff_in  input  MAX_COEFF*WIDTH  flattened block; coefficient i occupies bits [i*WIDTH +: WIDTH]; index 0 is the DC/lowest frequency
blk_len  input  5  number of valid coefficients for this block (4, 15 or 16); sampled with coeff_in
in_valid  input  1  block present
in_ready  output  1  block accepted when in_valid && in_ready
total_coeff  output  5  nonzero count, 0..16
total_zeros  output  4  zeros at indices below last_nz_idx, 0..15
trailing_ones  output  2  0..3
t1_signs  output  3  bit k = sign of k-th trailing one met in the scan (high index first); 1 = negative; unused bits 0
last_nz_idx  output  4  index of highest nonzero; 0 when total_coeff = 0
out_valid  output  1  results valid
out_ready  input  1  downstream accepts results

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high at a clk edge returns the FSM to IDLE.
- Reset values: out_valid = 0; total_coeff, total_zeros, trailing_ones, t1_signs and last_nz_idx = 0. in_ready = 1 (IDLE).
- FSM states are IDLE, SCAN, DONE. in_ready = (state == IDLE).
- IDLE:
  - On in_valid && in_ready, register coeff_in and the effective length L.
  - L = blk_len when 1 ≤ blk_len ≤ MAX_COEFF; otherwise L = MAX_COEFF.
  - Clear the accumulators, set idx = L-1, set t1_open = 1, and go to SCAN.
- SCAN: process one coefficient per cycle at idx.
  - Nonzero coefficient:
    - total_coeff++.
    - If this is the first nonzero met, record last_nz_idx = idx.
    - If t1_open and |c| == 1 and t1 < 3: t1++ and t1_signs[t1] = sign(c).
    - Otherwise, for any nonzero, clear t1_open. A nonzero with |c| ≠ 1, or a 4th ±1, ends trailing-ones counting permanently for the block.
  - Zero coefficient: no count change.
  - When idx == 0, go to DONE after this cycle; otherwise decrement idx.
- Indices ≥ L are ignored, whatever their contents.
- Magnitude rule: the most negative value (-2^(WIDTH-1)) is nonzero and not ±1. No abs() overflow is permitted to produce a false match.
- Entering DONE:
  - total_zeros = last_nz_idx + 1 - total_coeff, computed in 5 bits and truncated to 4. When total_coeff = 0, total_zeros = 0.
  - out_valid = 1.
- DONE:
  - Outputs hold stable while out_valid && !out_ready.
  - On out_ready, clear out_valid and go to IDLE.
  - The next block can be accepted on the cycle after the out handshake.
- Latency: out_valid rises exactly L clock edges after the accepting edge. Throughput is one block per L+2 cycles.
- in_valid while not in_ready is ignored; no data is captured.
- Reset mid-SCAN or mid-DONE: the partial result is discarded, out_valid falls, outputs clear, and in_ready = 1 after the reset edge.
- Result outputs are registered. They are only meaningful while out_valid = 1 and hold their last values otherwise.

Decomposition:
- Package cavlc_pkg holds:
  - the state encoding (IDLE/SCAN/DONE);
  - constants BLK_LUMA = 16, BLK_AC = 15, BLK_CDC = 4;
  - T1_MAX = 3;
  - the count-field widths (5, 4, 2, 3).
- One sub-module, cavlc_coeff_classify. It is purely combinational: WIDTH-bit coefficient in; is_zero, is_pm1 and sign out. It is instantiated once on the selected coefficient.

Test Plan:
- blk_len=16, coeffs idx0..15 = 0,3,-1,0,0,-1,1,0,1,0,… → total_coeff=5, total_zeros=4, trailing_ones=3, t1_signs=3'b100, last_nz_idx=8; out_valid exactly 16 edges after acceptance.
- blk_len=16, idx0..4 = 1,-1,1,1,-1, rest 0 → total_coeff=5, total_zeros=0, trailing_ones=3, t1_signs=3'b001, last_nz_idx=4.
- blk_len=4, idx0..3 = 0,0,2,0, idx4..15 = 5 → total_coeff=1, total_zeros=2, trailing_ones=0, last_nz_idx=2; latency 4.
- All-zero block, then a block with idx15 = -128 and idx14 = -1 → first block: all outputs 0. Second block: total_coeff=2, trailing_ones=0, total_zeros=14, last_nz_idx=15.
- out_ready low for 5 cycles in DONE, with in_valid high throughout → outputs stable, in_ready=0, no second capture. The second block is accepted the cycle after out_ready rises.
- rst pulsed for 1 cycle mid-SCAN (idx=7) → next cycle out_valid=0, outputs 0, in_ready=1. A subsequent block produces correct stats.
